// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Measures the half-periods of an asynchronous slow clock / toggle signal
//   (clk_in) in clk100MHz cycles, checks each against EXP_HALF +/- TOL and
//   flags a stuck input after TIMEOUT cycles without an edge. Out-of-tolerance
//   measurements and stuck events are tallied in a saturating error counter.
//
// Ports
//   clk100MHz   in   system clock
//   rst         in   synchronous, active-high reset
//   clk_in      in   asynchronous monitored signal
//   clear       in   synchronous clear of err_count (wins over an increment)
//   meas_valid  out  one-cycle pulse: new half_period / level / in_tol
//   half_period out  last measured interval in cycles (CW bits)
//   level       out  clk_in level during the measured interval
//   in_tol      out  |half_period - EXP_HALF| <= TOL
//   stuck       out  no edge seen for TIMEOUT cycles
//   err_count   out  saturating count of out-of-tolerance and stuck events
module clk_period_monitor #(
  parameter int CW       = 32,
  parameter int EXP_HALF = 10000,
  parameter int TOL      = 16,
  parameter int TIMEOUT  = 65536
) (
  input  logic          clk100MHz,
  input  logic          rst,
  input  logic          clk_in,
  input  logic          clear,
  output logic          meas_valid,
  output logic [CW-1:0] half_period,
  output logic          level,
  output logic          in_tol,
  output logic          stuck,
  output logic [15:0]   err_count
);

  // Lower bound clamps at zero so a TOL larger than EXP_HALF cannot wrap.
  localparam logic [CW-1:0] LO  = (EXP_HALF > TOL) ? CW'(EXP_HALF - TOL) : '0;
  localparam logic [CW-1:0] HI  = CW'(EXP_HALF + TOL);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, STUCK} state_t;

  state_t        state, state_n;
  logic          sync1, sync2, sync3;
  logic          edge_det;
  logic [CW-1:0] cnt;
  logic          take_meas, enter_stuck, leave_stuck;
  logic          meas_tol, err_inc;

  assign edge_det = sync2 ^ sync3;
  // cnt in the edge cycle is the interval since the previous detection.
  assign meas_tol = (cnt >= LO) && (cnt <= HI);
  assign err_inc  = enter_stuck | (take_meas & ~meas_tol);

  always_ff @(posedge clk100MHz) begin
    if (rst) state <= WAIT_FIRST;
    else     state <= state_n;
  end

  // An edge always takes priority over the timeout, so an edge landing on
  // the cycle cnt hits TIMEOUT is a (long) measurement, not a stuck event.
  always_comb begin
    state_n     = state;
    take_meas   = 1'b0;
    enter_stuck = 1'b0;
    leave_stuck = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (edge_det)        state_n = MEASURE;   // first interval is partial
        else if (cnt == TMO) begin
          state_n     = STUCK;
          enter_stuck = 1'b1;
        end
      end
      MEASURE: begin
        if (edge_det)        take_meas = 1'b1;
        else if (cnt == TMO) begin
          state_n     = STUCK;
          enter_stuck = 1'b1;
        end
      end
      STUCK: begin
        if (edge_det) begin                       // interval is invalid
          state_n     = MEASURE;
          leave_stuck = 1'b1;
        end
      end
      default: state_n = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      cnt         <= '0;
      meas_valid  <= 1'b0;
      half_period <= '0;
      level       <= 1'b0;
      in_tol      <= 1'b0;
      stuck       <= 1'b0;
      err_count   <= '0;
    end else begin
      sync1 <= clk_in;
      sync2 <= sync1;
      sync3 <= sync2;

      if (edge_det)       cnt <= CW'(1);
      else if (cnt < TMO) cnt <= cnt + CW'(1);

      meas_valid <= take_meas;
      if (take_meas) begin
        half_period <= cnt;
        level       <= sync3;              // level before the edge
        in_tol      <= meas_tol;
      end

      if (enter_stuck)      stuck <= 1'b1;
      else if (leave_stuck) stuck <= 1'b0;

      if (clear)                              err_count <= '0;
      else if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor. Main instance uses shortened intervals
// (EXP_HALF=200, TOL=16, TIMEOUT=1024); a second tiny instance
// (EXP_HALF=4, TOL=0, TIMEOUT=8, CW=8) runs in parallel to drive err_count
// into saturation.
module tb_clk_period_monitor;

  logic        clk100MHz;
  logic        rst, clk_in, clear;
  logic        meas_valid, level, in_tol, stuck;
  logic [31:0] half_period;
  logic [15:0] err_count;

  logic        rst_s, clk_in_s, clear_s;
  logic        meas_valid_s, level_s, in_tol_s, stuck_s;
  logic [7:0]  half_period_s;
  logic [15:0] err_count_s;

  int checks = 0;
  int errors = 0;

  clk_period_monitor #(.CW(32), .EXP_HALF(200), .TOL(16), .TIMEOUT(1024)) dut (
    .clk100MHz(clk100MHz), .rst(rst), .clk_in(clk_in), .clear(clear),
    .meas_valid(meas_valid), .half_period(half_period), .level(level),
    .in_tol(in_tol), .stuck(stuck), .err_count(err_count)
  );

  clk_period_monitor #(.CW(8), .EXP_HALF(4), .TOL(0), .TIMEOUT(8)) dut_s (
    .clk100MHz(clk100MHz), .rst(rst_s), .clk_in(clk_in_s), .clear(clear_s),
    .meas_valid(meas_valid_s), .half_period(half_period_s), .level(level_s),
    .in_tol(in_tol_s), .stuck(stuck_s), .err_count(err_count_s)
  );

  initial clk100MHz = 1'b0;
  always #5 clk100MHz = ~clk100MHz;

  typedef struct {
    int d;      // cycles from this toggle to the next one (0 = none)
    bit pulse;  // measurement expected for this toggle
    int hp;
    bit lvl;
    bit tol;
    int err;
    bit clr;
  } vec_t;

  vec_t tbl[9];

  task automatic step(input int n);
    repeat (n) @(negedge clk100MHz);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Toggle clk_in at a negedge; the result registers on the 3rd posedge after.
  // Returns one negedge after the pulse.
  task automatic toggle_check(input bit pulse, input int hp, input bit lvl,
                              input bit tol, input int err, input bit clr,
                              input string nm);
    clk_in = ~clk_in;
    step(2);
    chk({nm, " early_mv"}, 32'(meas_valid), 0);
    clear = clr;
    step(1);
    clear = 1'b0;
    chk({nm, " mv"}, 32'(meas_valid), 32'(pulse));
    if (pulse) begin
      chk({nm, " half_period"}, half_period, hp);
      chk({nm, " level"}, 32'(level), 32'(lvl));
      chk({nm, " in_tol"}, 32'(in_tol), 32'(tol));
    end
    chk({nm, " err_count"}, 32'(err_count), err);
    step(1);
    chk({nm, " mv_one_cycle"}, 32'(meas_valid), 0);
  endtask

  task automatic main_seq();
    tbl[0] = '{200,  0, 0,    0, 0, 0, 0};  // first edge: no pulse
    tbl[1] = '{200,  1, 200,  1, 1, 0, 0};
    tbl[2] = '{200,  1, 200,  0, 1, 0, 0};
    tbl[3] = '{216,  1, 200,  1, 1, 0, 0};
    tbl[4] = '{184,  1, 216,  0, 1, 0, 0};  // upper bound, inclusive
    tbl[5] = '{217,  1, 184,  1, 1, 0, 0};  // lower bound, inclusive
    tbl[6] = '{183,  1, 217,  0, 0, 1, 0};
    tbl[7] = '{1024, 1, 183,  1, 0, 2, 0};
    tbl[8] = '{0,    1, 1024, 0, 0, 3, 0};  // edge exactly at TIMEOUT

    rst = 1'b1; clk_in = 1'b0; clear = 1'b0;
    step(4);
    chk("rst mv", 32'(meas_valid), 0);
    chk("rst half_period", half_period, 0);
    chk("rst level", 32'(level), 0);
    chk("rst in_tol", 32'(in_tol), 0);
    chk("rst stuck", 32'(stuck), 0);
    chk("rst err_count", 32'(err_count), 0);
    rst = 1'b0;
    step(5);

    for (int i = 0; i < 9; i++) begin
      toggle_check(tbl[i].pulse, tbl[i].hp, tbl[i].lvl, tbl[i].tol,
                   tbl[i].err, tbl[i].clr, $sformatf("vec%0d", i));
      if (tbl[i].d > 0) step(tbl[i].d - 4);
    end

    // Hold clk_in: stuck after TIMEOUT cycles since the last detection.
    step(1022);
    chk("pre_stuck stuck", 32'(stuck), 0);
    chk("pre_stuck err", 32'(err_count), 3);
    step(1);
    chk("stuck stuck", 32'(stuck), 1);
    chk("stuck err", 32'(err_count), 4);
    step(40);
    chk("stuck hold", 32'(stuck), 1);
    chk("stuck err once", 32'(err_count), 4);

    // Resume: first edge only clears stuck.
    toggle_check(0, 0, 0, 0, 4, 0, "resume");
    chk("resume stuck", 32'(stuck), 0);
    step(196);
    toggle_check(1, 200, 0, 1, 4, 0, "after_resume");
    step(246);
    toggle_check(1, 250, 1, 0, 0, 1, "clear_vs_inc");
    step(196);
    toggle_check(1, 200, 0, 1, 0, 0, "after_clear");

    // Reset mid-interval; clk_in is high at release, which is the first edge.
    step(50);
    rst = 1'b1;
    step(1);
    chk("midrst mv", 32'(meas_valid), 0);
    chk("midrst half_period", half_period, 0);
    chk("midrst level", 32'(level), 0);
    chk("midrst in_tol", 32'(in_tol), 0);
    chk("midrst stuck", 32'(stuck), 0);
    chk("midrst err", 32'(err_count), 0);
    rst = 1'b0;
    step(2);
    chk("release early_mv", 32'(meas_valid), 0);
    step(1);
    chk("release first_edge_mv", 32'(meas_valid), 0);
    step(197);
    toggle_check(1, 200, 1, 1, 0, 0, "post_rst");
  endtask

  // Tiny build: one stuck event, then a toggle every cycle gives D=1 (out of
  // tolerance) on every cycle, so err_count climbs by one per cycle.
  task automatic small_seq();
    rst_s = 1'b1; clk_in_s = 1'b0; clear_s = 1'b0;
    step(3);
    rst_s = 1'b0;
    step(20);
    chk("s stuck", 32'(stuck_s), 1);
    chk("s stuck err", 32'(err_count_s), 1);
    for (int n = 1; n <= 65600; n++) begin
      clk_in_s = ~clk_in_s;
      step(1);
      if (n == 3) begin
        chk("s leave stuck", 32'(stuck_s), 0);
        chk("s leave err", 32'(err_count_s), 1);
        chk("s leave mv", 32'(meas_valid_s), 0);
      end
      if (n == 103) begin
        chk("s run err", 32'(err_count_s), 101);
        chk("s run mv", 32'(meas_valid_s), 1);
        chk("s run hp", 32'(half_period_s), 1);
        chk("s run tol", 32'(in_tol_s), 0);
      end
      if (n == 65536) chk("s near_sat", 32'(err_count_s), 65534);
      if (n == 65537) chk("s sat", 32'(err_count_s), 65535);
      if (n == 65600) chk("s sat hold", 32'(err_count_s), 65535);
    end
  endtask

  initial begin
    fork
      main_seq();
      small_seq();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
